// File: rtl/alu_issue_ctrl.sv
// Issue/control stage in front of the 64-bit ALU: decodes RV64I fields into ALU op/operands,
// captures the ALU result, and resolves BEQ/BNE. Optional custom-0 NOR decode via ALU_NOR_CUSTOM_EN.
module alu_issue_ctrl #(
  parameter int         XLEN       = 64,
  parameter logic [3:0] ILLEGAL_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Stage 1 (ALU input) registers
  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, tgt1_q, tgt1_d;
  logic [3:0]      op_q, op_d;
  logic            is_br_q, is_br_d, br_ne_q, br_ne_d, ill1_q, ill1_d;
  // Stage 2 (result) registers
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] res_q, res_d, tgt2_q, tgt2_d;
  logic            taken_q, taken_d, ill2_q, ill2_d;

  logic            s2_adv, accept;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_b;
  logic            dec_ill, dec_br;

  always_comb begin
    dec_op  = ILLEGAL_OP;
    dec_b   = rs2_data;
    dec_ill = 1'b1;
    dec_br  = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000) begin
          dec_op  = funct7_5 ? OP_SUB : OP_ADD;
          dec_ill = 1'b0;
        end else if (funct3 == 3'b111) begin
          dec_op  = OP_AND;
          dec_ill = 1'b0;
        end else if (funct3 == 3'b110) begin
          dec_op  = OP_OR;
          dec_ill = 1'b0;
        end
      end
      7'b0010011: begin
        dec_b = imm;
        if (funct3 == 3'b000) begin
          dec_op  = OP_ADD;
          dec_ill = 1'b0;
        end else if (funct3 == 3'b111) begin
          dec_op  = OP_AND;
          dec_ill = 1'b0;
        end else if (funct3 == 3'b110) begin
          dec_op  = OP_OR;
          dec_ill = 1'b0;
        end
      end
      7'b0000011, 7'b0100011: begin
        dec_op  = OP_ADD;
        dec_b   = imm;
        dec_ill = 1'b0;
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_op  = OP_SUB;
          dec_ill = 1'b0;
          dec_br  = 1'b1;
        end
      end
`ifdef ALU_NOR_CUSTOM_EN
      7'b0001011: begin
        if (funct3 == 3'b000) begin
          dec_op  = OP_NOR;
          dec_ill = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    is_br_d     = is_br_q;
    br_ne_d     = br_ne_q;
    tgt1_d      = tgt1_q;
    ill1_d      = ill1_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    taken_d     = taken_q;
    tgt2_d      = tgt2_q;
    ill2_d      = ill2_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = rs1_data;
      b_d        = dec_b;
      op_d       = dec_op;
      is_br_d    = dec_br;
      br_ne_d    = funct3[0];
      tgt1_d     = dec_br ? (pc + imm) : '0;
      ill1_d     = dec_ill;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // BEQ takes on zero, BNE on non-zero: the funct3 LSB selects the polarity
    if (s2_adv) begin
      out_valid_d = 1'b1;
      res_d       = alu_result;
      taken_d     = is_br_q & (br_ne_q ^ alu_zero);
      tgt2_d      = tgt1_q;
      ill2_d      = ill1_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'b0000;
      is_br_q     <= 1'b0;
      br_ne_q     <= 1'b0;
      tgt1_q      <= '0;
      ill1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      taken_q     <= 1'b0;
      tgt2_q      <= '0;
      ill2_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      is_br_q     <= is_br_d;
      br_ne_q     <= br_ne_d;
      tgt1_q      <= tgt1_d;
      ill1_q      <= ill1_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      taken_q     <= taken_d;
      tgt2_q      <= tgt2_d;
      ill2_q      <= ill2_d;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign out_valid     = out_valid_q;
  assign out_result    = res_q;
  assign branch_taken  = taken_q;
  assign branch_target = tgt2_q;
  assign illegal       = ill2_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed cases, back-pressure and randomized
// traffic scored against an instruction-level reference model.
module tb_alu_issue_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic            funct7_5 = 1'b0;
  logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
  logic [XLEN-1:0] alu_a, alu_b, alu_result, out_result, branch_target;
  logic [3:0]      alu_op;
  logic            alu_zero, out_valid, branch_taken, illegal;
  logic            out_ready = 1'b1;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .branch_taken(branch_taken), .branch_target(branch_target), .illegal(illegal)
  );

  // Behavioural Alu64
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] tgt;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic        taken;
    logic        ill;
    logic        chk_b;
  } exp_t;

  // Instruction-level model: what the instruction means, not how the stage encodes it
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                                 input logic [63:0] r1, input logic [63:0] r2,
                                 input logic [63:0] im, input logic [63:0] p);
    exp_t e;
    e = '0;
    e.a = r1;
    e.op = 4'b1111;
    e.ill = 1'b1;
    if (opc == 7'b0110011 && f3 == 3'b000) begin
      e.ill = 0; e.chk_b = 1; e.b = r2;
      if (f75) begin e.op = 4'b0110; e.res = r1 - r2; end
      else     begin e.op = 4'b0010; e.res = r1 + r2; end
    end else if ((opc == 7'b0110011 || opc == 7'b0010011) && (f3 == 3'b111 || f3 == 3'b110)) begin
      e.ill = 0; e.chk_b = 1;
      e.b = (opc == 7'b0110011) ? r2 : im;
      e.op = (f3 == 3'b111) ? 4'b0000 : 4'b0001;
      e.res = (f3 == 3'b111) ? (r1 & e.b) : (r1 | e.b);
    end else if ((opc == 7'b0010011 && f3 == 3'b000) || opc == 7'b0000011 || opc == 7'b0100011) begin
      e.ill = 0; e.chk_b = 1; e.b = im; e.op = 4'b0010; e.res = r1 + im;
    end else if (opc == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      e.ill = 0; e.chk_b = 1; e.b = r2; e.op = 4'b0110; e.res = r1 - r2;
      e.tgt = p + im;
      e.taken = (f3 == 3'b000) ? (r1 == r2) : (r1 != r2);
    end
`ifdef ALU_NOR_CUSTOM_EN
    else if (opc == 7'b0001011 && f3 == 3'b000) begin
      e.ill = 0; e.chk_b = 1; e.b = r2; e.op = 4'b1100; e.res = ~(r1 | r2);
    end
`endif
    return e;
  endfunction

  exp_t        sb_q[$];
  exp_t        s1_exp, got_e;
  bit          s1_pend = 0, stall_prev = 0, inrdy_prev = 1;
  logic [63:0] res_prev, a_prev;
  int          n_txn = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      s1_pend = 0;
      stall_prev = 0;
    end else begin
      if (s1_pend) begin
        check("s1_op", {60'd0, alu_op}, {60'd0, s1_exp.op});
        check("s1_a", alu_a, s1_exp.a);
        if (s1_exp.chk_b) check("s1_b", alu_b, s1_exp.b);
      end
      if (stall_prev) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", out_result, res_prev);
        if (!inrdy_prev) check("hold_alu_a", alu_a, a_prev);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          got_e = sb_q.pop_front();
          check("out_result", out_result, got_e.res);
          check("branch_taken", {63'd0, branch_taken}, {63'd0, got_e.taken});
          check("branch_target", branch_target, got_e.tgt);
          check("illegal", {63'd0, illegal}, {63'd0, got_e.ill});
          $display("txn %0d result=%h taken=%0b target=%h illegal=%0b",
                   n_txn, out_result, branch_taken, branch_target, illegal);
          n_txn++;
        end
      end
      s1_pend = in_valid && in_ready;
      if (s1_pend) begin
        s1_exp = model(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc);
        sb_q.push_back(s1_exp);
      end
      stall_prev = out_valid && !out_ready;
      inrdy_prev = in_ready;
      res_prev = out_result;
      a_prev = alu_a;
    end
  end

  // Present one instruction and return #1 after the edge that accepts it
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                      input logic [63:0] r1, input logic [63:0] r2,
                      input logic [63:0] im, input logic [63:0] p);
    bit ok;
    ok = 0;
    in_valid = 1; opcode = opc; funct3 = f3; funct7_5 = f75;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 0;
  endtask

  task automatic directed(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f75, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] im, input logic [63:0] p,
                          input logic [3:0] e_op, input logic [63:0] e_res,
                          input logic e_taken, input logic [63:0] e_tgt, input logic e_ill);
    out_ready = 1;
    send(opc, f3, f75, r1, r2, im, p);
    check({tag, "_op"}, {60'd0, alu_op}, {60'd0, e_op});
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_res"}, out_result, e_res);
    check({tag, "_taken"}, {63'd0, branch_taken}, {63'd0, e_taken});
    check({tag, "_tgt"}, branch_target, e_tgt);
    check({tag, "_ill"}, {63'd0, illegal}, {63'd0, e_ill});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_alu_op"}, {60'd0, alu_op}, 64'd0);
    check({tag, "_alu_a"}, alu_a, 64'd0);
    check({tag, "_alu_b"}, alu_b, 64'd0);
    check({tag, "_out_result"}, out_result, 64'd0);
    check({tag, "_taken"}, {63'd0, branch_taken}, 64'd0);
    check({tag, "_target"}, branch_target, 64'd0);
    check({tag, "_illegal"}, {63'd0, illegal}, 64'd0);
  endtask

  logic [6:0] opc_tab [0:6];
  logic [2:0] f3_tab  [0:4];
  bit         done;

  initial begin
    logic [6:0]  r_opc;
    logic [2:0]  r_f3;
    logic [63:0] r1, r2, im, p;
    logic [63:0] cust_res;
    logic        cust_ill;
    logic [3:0]  cust_op;

    opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0001011, 7'b1111111};
    f3_tab  = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 0;
    @(posedge clk);
    #1;

    // Reset while an ADD sits in stage 1
    out_ready = 1;
    send(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0);
    reset = 1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after_valid", {63'd0, out_valid}, 64'd0);
    check("rst_after_in_ready", {63'd0, in_ready}, 64'd1);

    directed("add", 7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0,
             4'b0010, 64'd12, 1'b0, 64'd0, 1'b0);
    directed("sub_wrap", 7'b0110011, 3'b000, 1'b1, 64'd0, 64'd1, 64'd0, 64'd0,
             4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0);
    directed("beq", 7'b1100011, 3'b000, 1'b0, 64'h42, 64'h42, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1000,
             4'b0110, 64'd0, 1'b1, 64'hFF8, 1'b0);
    directed("bne", 7'b1100011, 3'b001, 1'b0, 64'h42, 64'h42, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1000,
             4'b0110, 64'd0, 1'b0, 64'hFF8, 1'b0);
    directed("ill_r", 7'b0110011, 3'b001, 1'b0, 64'd9, 64'd3, 64'd0, 64'd0,
             4'b1111, 64'd0, 1'b0, 64'd0, 1'b1);
`ifdef ALU_NOR_CUSTOM_EN
    cust_op = 4'b1100; cust_res = 64'hFFFF_FFFF_FFFF_FFFF; cust_ill = 1'b0;
`else
    cust_op = 4'b1111; cust_res = 64'd0; cust_ill = 1'b1;
`endif
    directed("custom0", 7'b0001011, 3'b000, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0,
             cust_op, cust_res, 1'b0, 64'd0, cust_ill);

    // Back-pressure: three ADDIs with the consumer stalled for four cycles
    repeat (3) @(posedge clk);
    #1;
    fork
      begin
        send(7'b0010011, 3'b000, 1'b0, 64'd10, 64'd0, 64'd1, 64'd0);
        send(7'b0010011, 3'b000, 1'b0, 64'd10, 64'd0, 64'd2, 64'd0);
        send(7'b0010011, 3'b000, 1'b0, 64'd10, 64'd0, 64'd3, 64'd0);
      end
      begin
        out_ready = 0;
        repeat (4) @(negedge clk);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold", out_result, 64'd11);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", sb_q.size(), 64'd0);

    // Randomized traffic with random consumer stalls
    done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          r_opc = opc_tab[$urandom_range(0, 6)];
          if (r_opc == 7'b1111111) r_opc = 7'($urandom);
          r_f3 = f3_tab[$urandom_range(0, 4)];
          if ($urandom_range(0, 4) == 0) r_f3 = 3'($urandom);
          r1 = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
          r2 = ($urandom_range(0, 2) == 0) ? r1 : {$urandom, $urandom};
          im = {$urandom, $urandom};
          p  = {$urandom, $urandom};
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(r_opc, r_f3, 1'($urandom), r1, r2, im, p);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained", sb_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
